// File: rtl/ama_riscv_defines.sv
// Shared core definitions: per-stage register controls and pipeline sequencer state.
package ama_riscv_defines;

  typedef struct packed {
    logic en;
    logic bubble;
  } stage_ctrl_t;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_DRAIN  = 2'd1,
    PC_HALTED = 2'd2
  } pipe_ctrl_state_t;

  // Cycles from halt request in exe until the halting instruction has retired
  localparam logic [1:0] PIPE_DRAIN_CYCLES = 2'd3;

  function automatic stage_ctrl_t stage_ctrl(input logic en, input logic bubble);
    stage_ctrl_t c;
    c.en     = en;
    c.bubble = bubble;
    return c;
  endfunction

endpackage

// File: rtl/ama_riscv_perf_cnt.sv
// 32-bit event counter: increments on each cycle i_inc is high, wraps modulo 2^32.
module ama_riscv_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline sequencer: maps stall/flush/halt sources onto per-stage enables and bubbles.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module ama_riscv_pipe_ctrl
  import ama_riscv_defines::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_imem_valid,
  input  logic        i_dc_stalled,
  input  logic        i_load_use,
  input  logic        i_mispredict_mem,
  input  logic        i_halt_req_exe,
  output logic        o_fe_en,
  output logic        o_fe_redirect,
  output stage_ctrl_t o_ctrl_dec_exe,
  output stage_ctrl_t o_ctrl_exe_mem,
  output stage_ctrl_t o_ctrl_mem_wbk,
  output stage_ctrl_t o_ctrl_wbk_ret,
  output logic        o_halted,
  output logic [31:0] o_perf_dc_stall,
  output logic [31:0] o_perf_load_use,
  output logic [31:0] o_perf_flush
);

  pipe_ctrl_state_t r_state;
  logic             r_run;
  logic [1:0]       r_drain_cnt;
  logic             w_run_act;
  logic             w_halt_act;

  assign w_run_act  = r_run && (r_state == PC_RUN) && !i_dc_stalled;
  // A halt request is only honoured when no older event claims the cycle
  assign w_halt_act = w_run_act && !i_mispredict_mem && !i_load_use && i_halt_req_exe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run       <= 1'b0;
      r_state     <= PC_RUN;
      r_drain_cnt <= 2'd0;
    end else begin
      r_run <= 1'b1;
      if (w_halt_act) begin
        r_state     <= PC_DRAIN;
        r_drain_cnt <= PIPE_DRAIN_CYCLES;
      end else if (r_run && (r_state == PC_DRAIN) && !i_dc_stalled) begin
        r_drain_cnt <= r_drain_cnt - 2'd1;
        if (r_drain_cnt == 2'd1) r_state <= PC_HALTED;
      end
    end
  end

  always_comb begin
    o_fe_en        = 1'b0;
    o_fe_redirect  = 1'b0;
    o_ctrl_dec_exe = stage_ctrl(1'b0, 1'b1);
    o_ctrl_exe_mem = stage_ctrl(1'b0, 1'b1);
    o_ctrl_mem_wbk = stage_ctrl(1'b0, 1'b1);
    o_ctrl_wbk_ret = stage_ctrl(1'b0, 1'b1);
    if (r_run) begin
      o_ctrl_dec_exe = stage_ctrl(1'b0, 1'b0);
      o_ctrl_exe_mem = stage_ctrl(1'b0, 1'b0);
      o_ctrl_mem_wbk = stage_ctrl(1'b0, 1'b0);
      o_ctrl_wbk_ret = stage_ctrl(1'b0, 1'b0);
      unique case (r_state)
        PC_RUN: begin
          if (!i_dc_stalled) begin
            o_ctrl_dec_exe.en = 1'b1;
            o_ctrl_exe_mem.en = 1'b1;
            o_ctrl_mem_wbk.en = 1'b1;
            o_ctrl_wbk_ret.en = 1'b1;
            if (i_mispredict_mem) begin
              o_fe_en               = 1'b1;
              o_fe_redirect         = 1'b1;
              o_ctrl_dec_exe.bubble = 1'b1;
              o_ctrl_exe_mem.bubble = 1'b1;
            end else if (i_load_use) begin
              o_ctrl_dec_exe.bubble = 1'b1;
            end else begin
              o_fe_en               = 1'b1;
              o_ctrl_dec_exe.bubble = !i_imem_valid;
            end
          end
        end
        PC_DRAIN: begin
          o_ctrl_dec_exe.bubble = 1'b1;
          if (!i_dc_stalled) begin
            o_ctrl_dec_exe.en = 1'b1;
            o_ctrl_exe_mem.en = 1'b1;
            o_ctrl_mem_wbk.en = 1'b1;
            o_ctrl_wbk_ret.en = 1'b1;
          end
        end
        PC_HALTED: ;
        default: ;
      endcase
    end
  end

  assign o_halted = r_run && (r_state == PC_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic w_stall_evt;
  logic w_lu_evt;
  logic w_flush_evt;

  assign w_stall_evt = r_run && i_dc_stalled;
  assign w_flush_evt = w_run_act && i_mispredict_mem;
  assign w_lu_evt    = w_run_act && !i_mispredict_mem && i_load_use;

  ama_riscv_perf_cnt u_cnt_dc_stall (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_stall_evt),
    .o_cnt   (o_perf_dc_stall)
  );

  ama_riscv_perf_cnt u_cnt_load_use (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_lu_evt),
    .o_cnt   (o_perf_load_use)
  );

  ama_riscv_perf_cnt u_cnt_flush (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_flush_evt),
    .o_cnt   (o_perf_flush)
  );
`else
  assign o_perf_dc_stall = 32'd0;
  assign o_perf_load_use = 32'd0;
  assign o_perf_flush    = 32'd0;
`endif

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Directed bench for ama_riscv_pipe_ctrl with a cycle-level reference model and literal spot checks.
module tb_ama_riscv_pipe_ctrl;
  import ama_riscv_defines::*;

`ifdef PIPE_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid, dc_stalled, load_use, mispredict_mem, halt_req_exe;
  logic        fe_en, fe_redirect, halted;
  stage_ctrl_t ctrl_dec_exe, ctrl_exe_mem, ctrl_mem_wbk, ctrl_wbk_ret;
  logic [31:0] perf_dc_stall, perf_load_use, perf_flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ama_riscv_pipe_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_imem_valid     (imem_valid),
    .i_dc_stalled     (dc_stalled),
    .i_load_use       (load_use),
    .i_mispredict_mem (mispredict_mem),
    .i_halt_req_exe   (halt_req_exe),
    .o_fe_en          (fe_en),
    .o_fe_redirect    (fe_redirect),
    .o_ctrl_dec_exe   (ctrl_dec_exe),
    .o_ctrl_exe_mem   (ctrl_exe_mem),
    .o_ctrl_mem_wbk   (ctrl_mem_wbk),
    .o_ctrl_wbk_ret   (ctrl_wbk_ret),
    .o_halted         (halted),
    .o_perf_dc_stall  (perf_dc_stall),
    .o_perf_load_use  (perf_load_use),
    .o_perf_flush     (perf_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running, 1 = draining, 2 = stopped
  bit          m_run;
  int          m_mode;
  int          m_left;
  int unsigned m_dcs, m_lu, m_fl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_mode = 0; m_left = 0;
      m_dcs = 0; m_lu = 0; m_fl = 0;
    end else begin
      if (m_run) begin
        if (dc_stalled) m_dcs++;
        if (m_mode == 0 && !dc_stalled) begin
          if (mispredict_mem) m_fl++;
          else if (load_use) m_lu++;
          else if (halt_req_exe) begin
            m_mode = 1;
            m_left = 3;
          end
        end else if (m_mode == 1 && !dc_stalled) begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end
      m_run = 1;
    end
  end

  // Expected outputs as {fe_en, redirect, halted, {en,bub} x4}
  function automatic logic [10:0] model_out();
    bit en[4];
    bit bub[4];
    bit fe, rd, h;
    fe = 0; rd = 0; h = 0;
    for (int s = 0; s < 4; s++) begin en[s] = 0; bub[s] = 0; end
    if (!m_run) begin
      for (int s = 0; s < 4; s++) bub[s] = 1;
    end else if (m_mode == 2) begin
      h = 1;
    end else if (m_mode == 1) begin
      bub[0] = 1;
      if (!dc_stalled) for (int s = 0; s < 4; s++) en[s] = 1;
    end else if (!dc_stalled) begin
      for (int s = 0; s < 4; s++) en[s] = 1;
      if (mispredict_mem) begin
        fe = 1; rd = 1; bub[0] = 1; bub[1] = 1;
      end else if (load_use) begin
        bub[0] = 1;
      end else begin
        fe = 1; bub[0] = !imem_valid;
      end
    end
    return {fe, rd, h, en[0], bub[0], en[1], bub[1], en[2], bub[2], en[3], bub[3]};
  endfunction

  always @(negedge clk) begin
    chk("ctrl_vec", {21'd0, fe_en, fe_redirect, halted, ctrl_dec_exe, ctrl_exe_mem,
                     ctrl_mem_wbk, ctrl_wbk_ret}, {21'd0, model_out()});
    chk("perf_dc_stall", perf_dc_stall, PERF * m_dcs);
    chk("perf_load_use", perf_load_use, PERF * m_lu);
    chk("perf_flush", perf_flush, PERF * m_fl);
  end

  task automatic cyc(input logic iv, input logic dc, input logic lu, input logic mis, input logic hr);
    @(posedge clk); #1;
    imem_valid = iv; dc_stalled = dc; load_use = lu; mispredict_mem = mis; halt_req_exe = hr;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_valid = 1'b1; dc_stalled = 1'b0; load_use = 1'b0; mispredict_mem = 1'b0; halt_req_exe = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fe_en", fe_en, 0);
    chk("rst_dec_exe", ctrl_dec_exe, 2'b01);
    chk("rst_wbk_ret", ctrl_wbk_ret, 2'b01);
    chk("rst_halted", halted, 0);

    // Release: first cycle still idle, then full flow
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rel_c0_en", ctrl_exe_mem.en, 0);
    chk("rel_c0_fe_en", fe_en, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rel_c1_fe_en", fe_en, 1);
    chk("rel_c1_dec_exe", ctrl_dec_exe, 2'b10);
    chk("rel_c1_wbk_ret", ctrl_wbk_ret, 2'b10);
    cyc(0, 0, 0, 0, 0);
    chk("no_imem_dec_exe", ctrl_dec_exe, 2'b11);

    // Load-use bubble
    cyc(1, 0, 1, 0, 0);
    chk("lu_fe_en", fe_en, 0);
    chk("lu_dec_exe", ctrl_dec_exe, 2'b11);
    chk("lu_exe_mem", ctrl_exe_mem, 2'b10);
    cyc(1, 0, 0, 0, 0);
    chk("lu_perf", perf_load_use, PERF * 1);

    // Mispredict overrides load-use
    cyc(1, 0, 1, 1, 0);
    chk("mis_redirect", fe_redirect, 1);
    chk("mis_fe_en", fe_en, 1);
    chk("mis_dec_exe", ctrl_dec_exe, 2'b11);
    chk("mis_exe_mem", ctrl_exe_mem, 2'b11);
    chk("mis_mem_wbk", ctrl_mem_wbk, 2'b10);
    cyc(1, 0, 0, 0, 0);
    chk("mis_perf_flush", perf_flush, PERF * 1);
    chk("mis_perf_lu", perf_load_use, PERF * 1);

    // Mispredict overrides halt request
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    chk("mis_halt_ignored", fe_en, 1);

    // D-cache stall holds a pending mispredict
    repeat (4) begin
      cyc(1, 1, 0, 1, 0);
      chk("stall_redirect", fe_redirect, 0);
      chk("stall_mem_wbk_en", ctrl_mem_wbk.en, 0);
      chk("stall_fe_en", fe_en, 0);
    end
    cyc(1, 0, 0, 1, 0);
    chk("stall_rel_redirect", fe_redirect, 1);
    chk("stall_perf", perf_dc_stall, PERF * 4);

    // Halt with two stalled cycles mid-drain: halted six cycles after the pulse
    cyc(1, 0, 0, 0, 1);
    chk("halt_p_fe_en", fe_en, 1);
    cyc(1, 0, 0, 0, 0);
    chk("drain_fe_en", fe_en, 0);
    chk("drain_dec_exe", ctrl_dec_exe, 2'b11);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("drain_stall_en", ctrl_wbk_ret.en, 0);
    cyc(1, 0, 0, 1, 1);
    chk("drain_mis_ignored", fe_redirect, 0);
    cyc(1, 0, 1, 0, 0);
    chk("drain_last_halted", halted, 0);
    cyc(1, 0, 0, 1, 1);
    chk("halted_rise", halted, 1);
    chk("halted_redirect", fe_redirect, 0);
    chk("halted_dec_exe_en", ctrl_dec_exe.en, 0);
    cyc(1, 0, 0, 0, 1);
    chk("halted_stays", halted, 1);

    // Reset out of HALTED, then reset mid-drain
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    chk("rst_halted_clear", halted, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("drain2_fe_en", fe_en, 0);
    #1; rst_n = 1'b0;
    #1;
    chk("rst_drain_dec_exe", ctrl_dec_exe, 2'b01);
    chk("rst_drain_mem_wbk", ctrl_mem_wbk, 2'b01);
    chk("rst_drain_fe_en", fe_en, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_fe_en", fe_en, 1);
    chk("post_rst_perf_flush", perf_flush, 0);
    chk("post_rst_perf_dc", perf_dc_stall, 0);
    cyc(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
